// File: rtl/fetch_pkg.sv
// fetch_pkg: opcode constants, instruction field positions and FSM states for the fetch stage
package fetch_pkg;
  localparam logic [4:0] LDD_OP = 5'd10;
  localparam logic [4:0] POP_OP = 5'd9;
  localparam logic [15:0] NOP_WORD = 16'h0000;
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 11;
  localparam int SRC_HI = 10;
  localparam int SRC_LO = 8;
  localparam int DST_HI = 7;
  localparam int DST_LO = 5;
  typedef enum logic [1:0] {LOAD, RUN, BUBBLE} state_t;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags a new word that reads the register written by the previous LDD/POP
module load_use_detect
  import fetch_pkg::*;
(
  input  logic [15:0] prev,
  input  logic [15:0] next_word,
  output logic        hazard
);
  logic [4:0] opc;
  logic [2:0] src;
  logic [2:0] dst;
  always_comb begin
    opc = prev[OPC_HI:OPC_LO];
    src = next_word[SRC_HI:SRC_LO];
    dst = next_word[DST_HI:DST_LO];
    hazard = (opc == LDD_OP && (prev[DST_HI:DST_LO] == src || prev[DST_HI:DST_LO] == dst))
          || (opc == POP_OP && (prev[SRC_HI:SRC_LO] == src || prev[SRC_HI:SRC_LO] == dst));
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: program memory plus PC with redirects, stall/flush and load-use bubble insertion
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int DEPTH_LOG2 = 6,
  parameter int PC_W = 16,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(16'h0020)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            write_enable,
  input  logic [PC_W-1:0] write_addr,
  input  logic [15:0]     write_data,
  input  logic            stall,
  input  logic            flush,
  input  logic            jump_occured,
  input  logic [PC_W-1:0] jump_to,
  input  logic            direct_jump,
  input  logic [PC_W-1:0] direct_jump_to,
  output logic [15:0]     read_data,
  output logic [PC_W-1:0] fetch_pc,
  output logic            fetch_valid,
  output logic            hazard_stall
);
  logic [15:0] mem [2**DEPTH_LOG2];
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] npc;
  logic [15:0] fetched;
  logic hazard;
  logic bubble;
  logic unused_addr_bits;
  state_t state;
  state_t state_nx;
  assign unused_addr_bits = ^write_addr[PC_W-1:DEPTH_LOG2];
  assign npc = jump_occured ? jump_to : direct_jump ? direct_jump_to : pc + PC_W'(1);
  assign fetched = mem[npc[DEPTH_LOG2-1:0]];
  load_use_detect u_detect (.prev(read_data), .next_word(fetched), .hazard(hazard));
  assign bubble = state == RUN && !flush && hazard;
  always_comb begin
    state_nx = write_enable ? LOAD : stall ? state : bubble ? BUBBLE : RUN;
  end
  always_ff @(posedge clk) begin
    state <= rst ? RUN : state_nx;
  end
  always_ff @(posedge clk) begin
    if (!rst && write_enable) mem[write_addr[DEPTH_LOG2-1:0]] <= write_data;
  end
  // A bubble parks pc one behind npc so the default increment refetches the same target
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC - PC_W'(1);
      read_data <= NOP_WORD;
      fetch_pc <= '0;
      fetch_valid <= 1'b0;
      hazard_stall <= 1'b0;
    end else if (write_enable) begin
      fetch_valid <= 1'b0;
      hazard_stall <= 1'b0;
    end else if (stall) begin
      hazard_stall <= 1'b0;
    end else begin
      pc <= bubble ? npc - PC_W'(1) : npc;
      read_data <= (flush || bubble) ? NOP_WORD : fetched;
      fetch_pc <= bubble ? fetch_pc : npc;
      fetch_valid <= !flush && !bubble;
      hazard_stall <= bubble;
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed and random checks of the fetch stage against a behavioural model
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic write_enable = 1'b0;
  logic [15:0] write_addr = '0;
  logic [15:0] write_data = '0;
  logic stall = 1'b0;
  logic flush = 1'b0;
  logic jump_occured = 1'b0;
  logic [15:0] jump_to = '0;
  logic direct_jump = 1'b0;
  logic [15:0] direct_jump_to = '0;
  logic [15:0] read_data;
  logic [15:0] fetch_pc;
  logic fetch_valid;
  logic hazard_stall;
  int checks = 0;
  int errors = 0;
  logic [15:0] m_mem [64];
  logic [15:0] m_rd, m_fpc, m_seq;
  logic m_fv, m_hs;
  int m_mode;
  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .write_enable(write_enable), .write_addr(write_addr),
    .write_data(write_data), .stall(stall), .flush(flush), .jump_occured(jump_occured),
    .jump_to(jump_to), .direct_jump(direct_jump), .direct_jump_to(direct_jump_to),
    .read_data(read_data), .fetch_pc(fetch_pc), .fetch_valid(fetch_valid),
    .hazard_stall(hazard_stall)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic uses(input logic [2:0] r, input logic [15:0] w);
    return r == w[10:8] || r == w[7:5];
  endfunction
  // m_mode: 0 loading, 1 running, 2 just issued a bubble; m_seq is the next sequential fetch address
  task automatic model();
    logic [15:0] n, w;
    logic haz;
    if (rst) begin
      m_rd = 16'h0; m_fpc = 16'h0; m_fv = 1'b0; m_hs = 1'b0; m_mode = 1; m_seq = 16'h0020;
    end else if (write_enable) begin
      m_mem[write_addr[5:0]] = write_data; m_fv = 1'b0; m_hs = 1'b0; m_mode = 0;
    end else if (stall) begin
      m_hs = 1'b0;
    end else begin
      n = jump_occured ? jump_to : direct_jump ? direct_jump_to : m_seq;
      w = m_mem[n[5:0]];
      haz = m_mode == 1 && !flush &&
            ((m_rd[15:11] == 5'd10 && uses(m_rd[7:5], w)) ||
             (m_rd[15:11] == 5'd9 && uses(m_rd[10:8], w)));
      if (haz) begin
        m_rd = 16'h0; m_fv = 1'b0; m_hs = 1'b1; m_mode = 2; m_seq = n;
      end else begin
        m_rd = flush ? 16'h0 : w; m_fv = !flush; m_hs = 1'b0; m_fpc = n; m_mode = 1; m_seq = n + 16'd1;
      end
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model();
    #1;
    chk("read_data", read_data, m_rd);
    chk("fetch_pc", fetch_pc, m_fpc);
    chk("fetch_valid", 16'(fetch_valid), 16'(m_fv));
    chk("hazard_stall", 16'(hazard_stall), 16'(m_hs));
  endtask
  task automatic idle();
    rst = 1'b0; write_enable = 1'b0; stall = 1'b0; flush = 1'b0;
    jump_occured = 1'b0; direct_jump = 1'b0;
  endtask
  task automatic load(input logic [15:0] a, input logic [15:0] d);
    idle(); write_enable = 1'b1; write_addr = a; write_data = d;
    tick();
    write_enable = 1'b0;
  endtask
  task automatic jump(input logic [15:0] t);
    idle(); jump_occured = 1'b1; jump_to = t;
    tick();
    idle();
  endtask
  function automatic logic [15:0] rword();
    logic [4:0] opc;
    opc = ($urandom % 2 == 0) ? (($urandom % 2 == 0) ? 5'd10 : 5'd9) : 5'($urandom_range(0, 3));
    return {opc, 11'($urandom)};
  endfunction
  initial begin
    idle(); rst = 1'b1;
    tick();
    chk("reset read_data", read_data, 16'h0000);
    chk("reset fetch_pc", fetch_pc, 16'h0000);
    chk("reset fetch_valid", 16'(fetch_valid), 16'h0);
    for (int i = 0; i < 64; i++) load(16'(i), {5'($urandom_range(0, 3)), 11'($urandom)});
    load(16'd32, 16'h1111);
    load(16'd33, 16'h2222);
    idle(); tick();
    chk("first read_data", read_data, 16'h1111);
    chk("first fetch_pc", fetch_pc, 16'd32);
    chk("first fetch_valid", 16'(fetch_valid), 16'h1);
    tick();
    chk("second read_data", read_data, 16'h2222);
    chk("second fetch_pc", fetch_pc, 16'd33);
    rst = 1'b1; tick();
    load(16'd32, 16'h5060);
    load(16'd33, 16'h0B20);
    idle(); tick();
    chk("ldd word", read_data, 16'h5060);
    tick();
    chk("bubble read_data", read_data, 16'h0000);
    chk("bubble hazard_stall", 16'(hazard_stall), 16'h1);
    chk("bubble fetch_pc", fetch_pc, 16'd32);
    chk("bubble fetch_valid", 16'(fetch_valid), 16'h0);
    tick();
    chk("refetch read_data", read_data, 16'h0B20);
    chk("refetch fetch_pc", fetch_pc, 16'd33);
    chk("refetch no bubble", 16'(hazard_stall), 16'h0);
    jump_occured = 1'b1; jump_to = 16'd40; direct_jump = 1'b1; direct_jump_to = 16'd50;
    tick();
    chk("jump priority", fetch_pc, 16'd40);
    idle(); tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall hold", fetch_pc, 16'd41);
    end
    idle(); tick();
    chk("stall resume", fetch_pc, 16'd42);
    jump(16'hFFFF);
    tick();
    chk("wrap fetch_pc", fetch_pc, 16'h0000);
    chk("wrap read_data", read_data, m_mem[0]);
    jump(16'd64);
    chk("alias read_data", read_data, m_mem[0]);
    jump(16'd32);
    tick();
    chk("mid bubble", 16'(hazard_stall), 16'h1);
    rst = 1'b1; tick();
    idle(); tick();
    chk("post-reset fetch_pc", fetch_pc, 16'd32);
    chk("post-reset valid", 16'(fetch_valid), 16'h1);
    chk("post-reset no bubble", 16'(hazard_stall), 16'h0);
    flush = 1'b1; tick();
    chk("flush read_data", read_data, 16'h0000);
    chk("flush fetch_pc", fetch_pc, 16'd33);
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom % 60 == 0);
      write_enable = ($urandom % 12 == 0);
      write_addr = 16'($urandom);
      write_data = rword();
      stall = ($urandom % 6 == 0);
      flush = ($urandom % 8 == 0);
      jump_occured = ($urandom % 8 == 0);
      jump_to = ($urandom % 4 == 0) ? 16'($urandom) : 16'($urandom_range(0, 70));
      direct_jump = ($urandom % 8 == 0);
      direct_jump_to = 16'($urandom_range(0, 70));
      tick();
    end
    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Parametrised instruction-fetch stage with integrated program memory, replacing the fixed 64×16 fetch memory.
- Adds the following over the previous generation:
  - configurable depth, address width and reset vector;
  - redirect priority between conditional and direct jumps;
  - external pipeline stall and flush;
  - valid/PC tagging of the fetched word;
  - single-bubble load-use hazard injection.
- Sits between the program loader (write port) and the decode stage.

Parameters:
- DEPTH_LOG2, 6, memory depth = 2**DEPTH_LOG2 words; addresses index modulo depth
- PC_W, 16, PC and jump-target width
- RESET_PC, 16'h0020, address of first word fetched after reset
- LDD_OP, 5'd10, opcode whose destination field is [7:5]
- POP_OP, 5'd9, opcode whose destination field is [10:8]
- NOP_WORD, 16'h0000, bubble/flush encoding

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- write_enable  in  1  program-load write; freezes fetch
- write_addr  in  PC_W  load address (low DEPTH_LOG2 bits used)
- write_data  in  16  load word
- stall  in  1  downstream hold; fetch state frozen
- flush  in  1  squash current output word
- jump_occured  in  1  conditional-jump redirect
- jump_to  in  PC_W  conditional target
- direct_jump  in  1  unconditional redirect
- direct_jump_to  in  PC_W  unconditional target
- read_data  out  16  fetched instruction (registered)
- fetch_pc  out  PC_W  address of read_data
- fetch_valid  out  1  read_data is a real instruction
- hazard_stall  out  1  pulse: bubble inserted this cycle

Behaviour:
- Clocking: all state updates on posedge clk. Reset is synchronous, active-high, one clock.
- Reset values:
  - pc = RESET_PC-1 (mod 2**PC_W)
  - read_data = NOP_WORD
  - fetch_pc = 0
  - fetch_valid = 0
  - hazard_stall = 0
  - state = RUN
- Memory contents are not reset.
- FSM states:
  - LOAD: write_enable=1. Memory written; pc and outputs held; fetch_valid=0.
  - RUN: normal fetch.
  - BUBBLE: a hazard bubble was issued last cycle; hazard detection is suppressed for one fetch.
- Transitions:
  - any state → LOAD when write_enable=1
  - LOAD → RUN when write_enable=0
  - RUN → BUBBLE on hazard
  - BUBBLE → RUN on the next fetch cycle
- Fetch cycle condition: write_enable=0, rst=0, stall=0.
- Next-PC priority: jump_occured → jump_to; else direct_jump → direct_jump_to; else pc+1. Wrap modulo 2**PC_W.
- Fetch latency: on the fetch edge, read_data = mem[npc mod depth], fetch_pc = npc, fetch_valid = 1. There is zero-cycle latency from pc update to output.
- Hazard check (RUN only), with prev = read_data before the edge and new = mem[npc]:
  - (prev[15:11]==LDD_OP and prev[7:5] ∈ {new[10:8], new[7:5]}), or
  - (prev[15:11]==POP_OP and prev[10:8] ∈ {new[10:8], new[7:5]}).
- On hazard:
  - read_data = NOP_WORD, fetch_valid = 0, hazard_stall = 1;
  - pc is NOT advanced to npc; the same npc is refetched next cycle.
  - Applies to redirect targets too.
  - A redirect presented during the refetch cycle still wins.
- stall=1: pc, read_data, fetch_pc, fetch_valid and state are held. hazard_stall = 0.
- flush=1 on a fetch cycle:
  - pc advances normally;
  - read_data = NOP_WORD, fetch_valid = 0;
  - hazard check is skipped and state goes to RUN.
- Priority order: rst > write_enable > stall > flush > hazard.
- Simultaneous write and fetch cannot occur, because write freezes fetch.
- A write to the address about to be fetched takes effect on the next fetch.

Decomposition:
- Package fetch_pkg holds:
  - opcode constants LDD_OP and POP_OP;
  - field slice positions (OPC [15:11], SRC [10:8], DST [7:5]);
  - NOP_WORD;
  - FSM state enum {LOAD, RUN, BUBBLE}.
- One sub-module, load_use_detect: combinational prev/new comparator producing the hazard signal. Memory and PC remain in the top module.

Test Plan:
- Reset, preload mem[32]=16'h1111 and mem[33]=16'h2222, then release write_enable → read_data=1111/fetch_pc=32, then 2222/33, fetch_valid=1.
- mem[32]={LDD,3'b000,3'b011,5'b0} and mem[33]={5'd1,3'b011,3'b001,5'b0} → cycle 1 gives LDD, cycle 2 gives NOP with hazard_stall=1 and fetch_pc=32, cycle 3 gives mem[33] with fetch_pc=33 and no second bubble.
- jump_occured=1 (jump_to=40) and direct_jump=1 (direct_jump_to=50) together → fetch_pc=40.
- stall held for 3 cycles mid-stream → outputs unchanged for 3 cycles, then resume at pc+1 with no skipped address.
- pc=16'hFFFF increments → fetch_pc=0 and read_data=mem[0]; a fetch of address 64 with DEPTH_LOG2=6 returns mem[0].
- rst asserted one cycle in the middle of a hazard bubble → next fetch is at RESET_PC, fetch_valid=1, no bubble.
